// File: rtl/rx_measure_ctrl.sv
// rtl/rx_measure_ctrl.sv - sequencer for the Rx = A2*R_REF/(A1-A2) measurement datapath
//
// Averages 2^AVG_LOG2 ADC samples of channel A1 and then of channel A2.
// It checks that A1avg > A2avg, presents the divider operands, and waits DIV_LAT cycles.
// It then publishes a quotient saturated to 11 bits.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                one-cycle pulse that starts a measurement (ignored while busy)
//   cont_i                 restart automatically after DONE/ERR
//   adc_req_o, adc_ch_o    conversion request and channel (0 = A1, 1 = A2)
//   adc_ack_i, adc_data_i  conversion result strobe and data
//   div_a_o, div_b_o       divider dividend / divisor, held until the next CHECK
//   div_q_i                divider quotient
//   result_o               last good Rx, saturated to 11'h7FF
//   result_valid_o         one-cycle pulse when result_o updates
//   busy_o                 high outside IDLE
//   err_denom_o            sticky: A1avg <= A2avg
//   err_timeout_o          sticky: no adc_ack within TIMEOUT cycles of a request
//   ovf_o                  sticky: quotient exceeded 2047
module rx_measure_ctrl #(
    parameter logic [13:0] R_REF    = 14'd10000,
    parameter int          AVG_LOG2 = 2,
    parameter int          DIV_LAT  = 26,
    parameter int          TIMEOUT  = 1023
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        cont_i,
    output logic        adc_req_o,
    output logic        adc_ch_o,
    input  logic        adc_ack_i,
    input  logic [11:0] adc_data_i,
    output logic [25:0] div_a_o,
    output logic [25:0] div_b_o,
    input  logic [25:0] div_q_i,
    output logic [10:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic        err_denom_o,
    output logic        err_timeout_o,
    output logic        ovf_o
);

    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int DIV_W  = $clog2(DIV_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMP_A1,
        S_SAMP_A2,
        S_CHECK,
        S_DIVIDE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [15:0]         acc1_q;
    logic [15:0]         acc2_q;
    logic [4:0]          samp_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic                adc_req_q;
    logic                adc_ch_q;
    logic [25:0]         div_a_q;
    logic [25:0]         div_b_q;
    logic [10:0]         result_q;
    logic                result_valid_q;
    logic                busy_q;
    logic                err_denom_q;
    logic                err_timeout_q;
    logic                ovf_q;

    logic [15:0]         acc_sum_d;
    logic [11:0]         avg1_d;
    logic [11:0]         avg2_d;
    logic [25:0]         prod_d;
    logic                last_samp_d;
    logic                restart_d;

    // Accumulator of the channel currently being sampled plus the new sample.
    assign acc_sum_d   = (adc_ch_q ? acc2_q : acc1_q) + {4'b0, adc_data_i};
    assign avg1_d      = 12'(acc1_q >> AVG_LOG2);
    assign avg2_d      = 12'(acc2_q >> AVG_LOG2);
    assign prod_d      = 26'(avg2_d) * 26'(R_REF);
    assign last_samp_d = (samp_q == 5'(NSAMP - 1));

    // A start in IDLE and an auto-restart out of DONE/ERR share the same entry path.
    assign restart_d = ((state_q == S_IDLE) && start_i) ||
                       (((state_q == S_DONE) || (state_q == S_ERR)) && cont_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            acc1_q         <= '0;
            acc2_q         <= '0;
            samp_q         <= '0;
            wait_q         <= '0;
            div_cnt_q      <= '0;
            adc_req_q      <= 1'b0;
            adc_ch_q       <= 1'b0;
            div_a_q        <= '0;
            div_b_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_denom_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (restart_d) begin
                state_q       <= S_SAMP_A1;
                acc1_q        <= '0;
                acc2_q        <= '0;
                samp_q        <= '0;
                wait_q        <= '0;
                adc_req_q     <= 1'b1;
                adc_ch_q      <= 1'b0;
                busy_q        <= 1'b1;
                err_denom_q   <= 1'b0;
                err_timeout_q <= 1'b0;
                ovf_q         <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_SAMP_A1, S_SAMP_A2: begin
                        if (!adc_req_q) begin
                            // One-cycle gap after each ack (and after a channel switch).
                            adc_req_q <= 1'b1;
                            wait_q    <= '0;
                        end else if (adc_ack_i) begin
                            if (adc_ch_q) begin
                                acc2_q <= acc_sum_d;
                            end else begin
                                acc1_q <= acc_sum_d;
                            end
                            adc_req_q <= 1'b0;
                            if (last_samp_d) begin
                                samp_q <= '0;
                                if (state_q == S_SAMP_A1) begin
                                    state_q  <= S_SAMP_A2;
                                    adc_ch_q <= 1'b1;
                                end else begin
                                    state_q <= S_CHECK;
                                end
                            end else begin
                                samp_q <= samp_q + 1'b1;
                            end
                        end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                            state_q       <= S_ERR;
                            adc_req_q     <= 1'b0;
                            err_timeout_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (avg1_d <= avg2_d) begin
                            state_q     <= S_ERR;
                            err_denom_q <= 1'b1;
                        end else begin
                            div_a_q   <= prod_d;
                            div_b_q   <= {14'b0, avg1_d - avg2_d};
                            div_cnt_q <= '0;
                            state_q   <= S_DIVIDE;
                        end
                    end
                    S_DIVIDE: begin
                        // Operands have been stable for DIV_LAT cycles at this edge.
                        if (div_cnt_q == DIV_W'(DIV_LAT - 1)) begin
                            state_q        <= S_DONE;
                            result_valid_q <= 1'b1;
                            if (div_q_i > 26'd2047) begin
                                result_q <= 11'h7FF;
                                ovf_q    <= 1'b1;
                            end else begin
                                result_q <= div_q_i[10:0];
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 1'b1;
                        end
                    end
                    S_DONE, S_ERR: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adc_req_o      = adc_req_q;
    assign adc_ch_o       = adc_ch_q;
    assign div_a_o        = div_a_q;
    assign div_b_o        = div_b_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = busy_q;
    assign err_denom_o    = err_denom_q;
    assign err_timeout_o  = err_timeout_q;
    assign ovf_o          = ovf_q;

endmodule
